// File: rtl/mvm_axis_cmd_tx.sv
// rtl/mvm_axis_cmd_tx.sv - Host-side AXIS transmitter producing tuser-encoded MVM flits from commands and payload.
module mvm_axis_cmd_tx #(
    parameter int DATAW   = 512,
    parameter int BYTEW   = 8,
    parameter int IDW     = 32,
    parameter int DESTW   = 12,
    parameter int USERW   = 75,
    parameter int RFADDRW = 9,
    parameter int DPES    = 64,
    parameter int DPESW   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RFADDRW-1:0] cmd_rf_addr,
    input  logic [DPESW-1:0]   cmd_dpe_start,
    input  logic [DPESW:0]     cmd_len,
    input  logic [DESTW-1:0]   cmd_dest,
    input  logic [31:0]        cmd_inst,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [DATAW-1:0]   data_word,
    output logic               axis_tx_tvalid,
    output logic [DATAW-1:0]   axis_tx_tdata,
    output logic [BYTEW-1:0]   axis_tx_tstrb,
    output logic [BYTEW-1:0]   axis_tx_tkeep,
    output logic [IDW-1:0]     axis_tx_tid,
    output logic [DESTW-1:0]   axis_tx_tdest,
    output logic [USERW-1:0]   axis_tx_tuser,
    output logic               axis_tx_tlast,
    input  logic               axis_tx_tready,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    localparam logic [1:0] OP_WEIGHT = 2'b11;
    localparam logic [1:0] OP_INST   = 2'b00;

    state_t             state;
    logic [1:0]         op_q;
    logic [RFADDRW-1:0] rf_addr_q;
    logic [DPESW-1:0]   dpe_start_q;
    logic [DPESW-1:0]   cnt_q;
    logic [DPESW:0]     rem_q;
    logic [DESTW-1:0]   dest_q;
    logic [31:0]        inst_q;

    logic               slot_can_load;
    logic               cmd_fire;
    logic               data_fire;
    logic               inst_fire;
    logic [DPESW-1:0]   dpe_idx;
    logic [DPES-1:0]    dpe_sel;
    logic [RFADDRW-1:0] user_rf;
    logic [USERW-1:0]   data_user;

    // The slot accepts a new beat when empty or when its current beat leaves this cycle.
    assign slot_can_load = !axis_tx_tvalid || axis_tx_tready;

    // Gating with rst keeps both handshakes closed while reset is held.
    assign cmd_ready  = rst && (state == IDLE) && slot_can_load;
    assign data_ready = rst && (state == DATA) && slot_can_load;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign data_fire  = data_valid && data_ready;
    assign inst_fire  = (state == INST) && slot_can_load;

    // DPE index wraps naturally at DPESW bits (63 -> 0).
    assign dpe_idx   = dpe_start_q + cnt_q;
    assign dpe_sel   = (op_q == OP_WEIGHT) ? ({{(DPES-1){1'b0}}, 1'b1} << dpe_idx) : '0;
    assign user_rf   = (op_q == OP_WEIGHT) ? rf_addr_q : '0;
    assign data_user = {dpe_sel, op_q, user_rf};

    assign busy = (state != IDLE) || axis_tx_tvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op_q           <= '0;
            rf_addr_q      <= '0;
            dpe_start_q    <= '0;
            cnt_q          <= '0;
            rem_q          <= '0;
            dest_q         <= '0;
            inst_q         <= '0;
            axis_tx_tvalid <= 1'b0;
            axis_tx_tdata  <= '0;
            axis_tx_tstrb  <= '0;
            axis_tx_tkeep  <= '0;
            axis_tx_tid    <= '0;
            axis_tx_tdest  <= '0;
            axis_tx_tuser  <= '0;
            axis_tx_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        op_q        <= cmd_op;
                        rf_addr_q   <= cmd_rf_addr;
                        dpe_start_q <= cmd_dpe_start;
                        dest_q      <= cmd_dest;
                        inst_q      <= cmd_inst;
                        cnt_q       <= '0;
                        if (cmd_op == OP_INST) begin
                            state <= INST;
                        end else begin
                            state <= DATA;
                            if (cmd_op != OP_WEIGHT)
                                rem_q <= (DPESW+1)'(1);
                            else if (cmd_len == '0)
                                rem_q <= (DPESW+1)'(DPES);
                            else
                                rem_q <= cmd_len;
                        end
                    end
                end
                DATA: begin
                    if (data_fire) begin
                        cnt_q <= cnt_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == (DPESW+1)'(1))
                            state <= IDLE;
                    end
                end
                INST: begin
                    if (slot_can_load)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Output slot: holds while stalled, otherwise loads or empties.
            if (slot_can_load) begin
                axis_tx_tvalid <= data_fire || inst_fire;
                if (data_fire || inst_fire) begin
                    axis_tx_tstrb <= '1;
                    axis_tx_tkeep <= '1;
                    axis_tx_tid   <= '0;
                    axis_tx_tdest <= dest_q;
                    axis_tx_tlast <= 1'b1;
                end
                if (data_fire) begin
                    axis_tx_tdata <= data_word;
                    axis_tx_tuser <= data_user;
                end else if (inst_fire) begin
                    axis_tx_tdata <= {{(DATAW-32){1'b0}}, inst_q};
                    axis_tx_tuser <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_axis_cmd_tx.sv
// tb/tb_mvm_axis_cmd_tx.sv - Directed self-checking bench for mvm_axis_cmd_tx.
module tb_mvm_axis_cmd_tx;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [8:0]   cmd_rf_addr;
    logic [5:0]   cmd_dpe_start;
    logic [6:0]   cmd_len;
    logic [11:0]  cmd_dest;
    logic [31:0]  cmd_inst;
    logic         data_valid;
    logic         data_ready;
    logic [511:0] data_word;
    logic         tvalid;
    logic [511:0] tdata;
    logic [7:0]   tstrb;
    logic [7:0]   tkeep;
    logic [31:0]  tid;
    logic [11:0]  tdest;
    logic [74:0]  tuser;
    logic         tlast;
    logic         tready;
    logic         busy;

    logic         tready_man = 1'b1;
    logic         bp_mode = 1'b0;
    logic         bp_tready = 1'b1;
    logic [3:0]   bp_pat = 4'b1001;
    logic [1:0]   bp_idx = 2'd0;

    int checks = 0;
    int failures = 0;

    logic [511:0] beat_data[$];
    logic [74:0]  beat_user[$];
    logic [11:0]  beat_dest[$];
    logic         beat_last[$];
    logic         beat_const[$];
    int           stab_err = 0;
    int           dr_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [648:0] snap = '0;

    assign tready = bp_mode ? bp_tready : tready_man;

    mvm_axis_cmd_tx dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_rf_addr    (cmd_rf_addr),
        .cmd_dpe_start  (cmd_dpe_start),
        .cmd_len        (cmd_len),
        .cmd_dest       (cmd_dest),
        .cmd_inst       (cmd_inst),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data_word      (data_word),
        .axis_tx_tvalid (tvalid),
        .axis_tx_tdata  (tdata),
        .axis_tx_tstrb  (tstrb),
        .axis_tx_tkeep  (tkeep),
        .axis_tx_tid    (tid),
        .axis_tx_tdest  (tdest),
        .axis_tx_tuser  (tuser),
        .axis_tx_tlast  (tlast),
        .axis_tx_tready (tready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // tready pattern 1,0,0,1 repeating when backpressure mode is on
    always @(posedge clk) begin
        #1;
        bp_tready = bp_pat[bp_idx];
        bp_idx = bp_idx + 2'd1;
    end

    // Beat monitor: handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst && tvalid && tready) begin
            beat_data.push_back(tdata);
            beat_user.push_back(tuser);
            beat_dest.push_back(tdest);
            beat_last.push_back(tlast);
            beat_const.push_back((tstrb == 8'hFF) && (tkeep == 8'hFF) && (tid == 32'd0));
        end
        if (rst && data_ready)
            dr_cnt++;
        if (rst && prev_stall && ({tvalid, tdata, tuser, tdest, tlast, tstrb, tkeep, tid} !== snap))
            stab_err++;
        prev_stall = rst && tvalid && !tready;
        snap = {tvalid, tdata, tuser, tdest, tlast, tstrb, tkeep, tid};
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [8:0] rf, input logic [5:0] st,
                          input logic [6:0] len, input logic [11:0] dest, input logic [31:0] inst);
        logic ok;
        ok = 1'b0;
        cmd_op = op; cmd_rf_addr = rf; cmd_dpe_start = st; cmd_len = len;
        cmd_dest = dest; cmd_inst = inst; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_handshake", ok, 1);
    endtask

    task automatic feed(input logic [511:0] w);
        logic ok;
        ok = 1'b0;
        data_word = w; data_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        if (!ok) chk("data_handshake", ok, 1);
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 400; i++) begin
            if (beat_data.size() >= n) break;
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk(tag, beat_data.size(), n);
    endtask

    initial begin
        int base, d0, s0;
        int sel_bits[4];
        logic [74:0] eu;
        logic [511:0] w;

        cmd_valid = 0; cmd_op = 0; cmd_rf_addr = 0; cmd_dpe_start = 0; cmd_len = 0;
        cmd_dest = 0; cmd_inst = 0; data_valid = 0; data_word = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);

        // Weight burst with wrap 62,63,0,1
        sel_bits = '{73, 74, 11, 12};
        base = beat_data.size();
        do_cmd(2'b11, 9'd1, 6'd62, 7'd4, 12'h0A5, 32'h0);
        for (int i = 0; i < 4; i++) feed({16{32'hA000_0000 + i}});
        wait_beats("wrap_count", base + 4);
        for (int i = 0; i < 4; i++) begin
            eu = 75'h601 | (75'd1 << sel_bits[i]);
            w = {16{32'hA000_0000 + i}};
            chk("wrap_tuser", beat_user[base+i], eu);
            chk("wrap_tdata", beat_data[base+i], w);
            chk("wrap_tlast", beat_last[base+i], 1);
            chk("wrap_tdest", beat_dest[base+i], 12'h0A5);
            chk("wrap_const", beat_const[base+i], 1);
        end

        // Full 64-beat burst, len=0
        base = beat_data.size();
        do_cmd(2'b11, 9'd300, 6'd0, 7'd0, 12'h7FF, 32'h0);
        for (int i = 0; i < 64; i++) begin
            feed({480'd0, 32'hB000_0000 + i});
            if (i == 10) begin
                chk("burst_no_cmd_ready", cmd_ready, 0);
                chk("burst_busy", busy, 1);
            end
        end
        wait_beats("full_count", base + 64);
        chk("full_busy_done", busy, 0);
        for (int i = 0; i < 64; i++) begin
            eu = 75'h72C | (75'd1 << (11 + i));
            chk("full_tuser", beat_user[base+i], eu);
            chk("full_tdata", beat_data[base+i], {480'd0, 32'hB000_0000 + i});
        end

        // Vectors
        base = beat_data.size();
        do_cmd(2'b10, 9'h1AB, 6'd5, 7'd9, 12'h123, 32'h0);
        feed({64{8'h01}});
        do_cmd(2'b01, 9'h0FF, 6'd7, 7'd3, 12'h456, 32'h0);
        feed({64{8'h02}});
        wait_beats("vec_count", base + 2);
        chk("vec_in_tuser", beat_user[base], 75'h400);
        chk("vec_in_tdata", beat_data[base], {64{8'h01}});
        chk("vec_in_tdest", beat_dest[base], 12'h123);
        chk("vec_rd_tuser", beat_user[base+1], 75'h200);
        chk("vec_rd_tdata", beat_data[base+1], {64{8'h02}});
        chk("vec_rd_tdest", beat_dest[base+1], 12'h456);

        // Instruction with data_valid held high
        base = beat_data.size();
        data_word = {16{32'hDEAD_BEEF}};
        data_valid = 1'b1;
        d0 = dr_cnt;
        do_cmd(2'b00, 9'd0, 6'd0, 7'd0, 12'h0F0, 32'h8000_200E);
        wait_beats("inst_count", base + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("inst_no_data_ready", dr_cnt, d0);
        chk("inst_single_beat", beat_data.size(), base + 1);
        chk("inst_tdata", beat_data[base], {480'd0, 32'h8000_200E});
        chk("inst_tuser", beat_user[base], 75'd0);
        chk("inst_tdest", beat_dest[base], 12'h0F0);
        chk("inst_tlast", beat_last[base], 1);
        data_valid = 1'b0;

        // Backpressure: tready 1,0,0,1,...
        base = beat_data.size();
        s0 = stab_err;
        bp_mode = 1'b1;
        do_cmd(2'b11, 9'd5, 6'd10, 7'd3, 12'h033, 32'h0);
        for (int i = 0; i < 3; i++) feed({16{32'hC000_0000 + i}});
        wait_beats("bp_count", base + 3);
        repeat (5) @(posedge clk);
        #1;
        bp_mode = 1'b0;
        chk("bp_no_dup", beat_data.size(), base + 3);
        chk("bp_stable", stab_err, s0);
        for (int i = 0; i < 3; i++) begin
            eu = 75'h605 | (75'd1 << (21 + i));
            chk("bp_tuser", beat_user[base+i], eu);
            chk("bp_tdata", beat_data[base+i], {16{32'hC000_0000 + i}});
        end

        // Reset abort during beat 2
        base = beat_data.size();
        tready_man = 1'b0;
        do_cmd(2'b11, 9'd2, 6'd0, 7'd3, 12'h011, 32'h0);
        feed({16{32'h1111_1111}});
        tready_man = 1'b1;
        data_word = {16{32'h2222_2222}};
        data_valid = 1'b1;
        @(posedge clk); #1;
        tready_man = 1'b0;
        data_valid = 1'b0;
        chk("abort_beat2_present", tvalid, 1);
        chk("abort_beat2_data", tdata, {16{32'h2222_2222}});
        #2;
        rst = 1'b0;
        #1;
        chk("abort_tvalid_async", tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tready_man = 1'b1;
        chk("abort_only_beat1", beat_data.size(), base + 1);
        chk("abort_beat1_data", beat_data[base], {16{32'h1111_1111}});
        base = beat_data.size();
        do_cmd(2'b10, 9'd0, 6'd0, 7'd0, 12'h321, 32'h0);
        feed({8{64'h0123_4567_89AB_CDEF}});
        wait_beats("post_abort_count", base + 1);
        chk("post_abort_tuser", beat_user[base], 75'h400);
        chk("post_abort_tdata", beat_data[base], {8{64'h0123_4567_89AB_CDEF}});
        chk("post_abort_tdest", beat_dest[base], 12'h321);
        chk("post_abort_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mvm_axis_cmd_tx.md
Name: mvm_axis_cmd_tx

Overview:
- Host-side AXI-stream transmitter for the rtl_mvm rx port. It is the initiator that produces the tuser-encoded flits the MVM consumes.
- Accepts high-level commands on a valid/ready port and payload words on a separate stream:
  - weight bursts to register files
  - input vectors
  - reduction vectors
  - instructions
- Emits correctly encoded AXIS beats at up to one per cycle, with full backpressure support.

Parameters:
- DATAW 512: tdata width.
- BYTEW 8: tstrb/tkeep width.
- IDW 32: tid width.
- DESTW 12: tdest width.
- USERW 75: tuser width, which is 11 + DPES.
- RFADDRW 9: register-file address width.
- DPES 64: number of DPEs, equal to the width of the one-hot RF-select field.
- DPESW 6: log2(DPES).

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-low reset.
- cmd_valid in 1: command valid.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_op in 2: 11 = weight write, 10 = input vector, 01 = reduction vector, 00 = instruction.
- cmd_rf_addr in RFADDRW: RF address for weight writes.
- cmd_dpe_start in DPESW: first DPE of a weight burst.
- cmd_len in DPESW+1: weight beats, 1..DPES; 0 means DPES.
- cmd_dest in DESTW: tdest for every beat of the command.
- cmd_inst in 32: instruction word, bit fields:
  - [0] RDC
  - [1] ACM_EN
  - [2] RLS
  - [3] LST
  - [12:4] ACCUM_ADDR
  - [21:13] RF_ADDR
  - [30:22] RLS_DEST
  - [31] RLS_OP
- data_valid in 1: payload word valid.
- data_ready out 1: payload word consumed.
- data_word in DATAW: payload.
- axis_tx_tvalid out 1, axis_tx_tdata out DATAW, axis_tx_tstrb out BYTEW, axis_tx_tkeep out BYTEW, axis_tx_tid out IDW, axis_tx_tdest out DESTW, axis_tx_tuser out USERW, axis_tx_tlast out 1.
- axis_tx_tready in 1.
- busy out 1: high whenever state != IDLE or axis_tx_tvalid is high.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, beat counter = 0.
  - All axis_tx_* outputs = 0.
  - cmd_ready = 0, data_ready = 0, busy = 0.
  - First command can be accepted on the first clk edge after rst deasserts.
  - rst asserted mid-burst aborts immediately. The partial burst is dropped and tvalid drops asynchronously.
- Output stage is a single output register ("slot"):
  - The slot loads when it is empty or when axis_tx_tvalid && axis_tx_tready in the same cycle.
  - While tvalid && !tready, all axis_tx_* outputs hold stable.
  - Back-to-back beats therefore sustain one per cycle under continuous tready.
- Constant fields on every beat:
  - tstrb = tkeep = all ones.
  - tid = 0.
  - tdest = latched cmd_dest.
  - tlast = 1, because every beat is a one-flit packet.
- FSM states: IDLE, DATA, INST.
  - IDLE:
    - cmd_ready = 1 iff the slot is empty or draining this cycle.
    - On accept, latch the command fields.
    - op 00 goes to INST. All other ops go to DATA with counter = 0 and remaining = cmd_len, where 0 maps to DPES.
  - INST:
    - Load the slot with tdata[31:0] = cmd_inst and tdata[DATAW-1:32] = 0.
    - tuser = 0, so tuser[10:9] = 00 and the select field is 0.
    - No data stream is consumed.
    - Return to IDLE.
    - The beat is visible on tvalid in the cycle after the command is accepted.
  - DATA:
    - data_ready = 1 iff the slot can load this cycle.
    - On data_valid && data_ready, load the slot with tdata = data_word.
    - tuser[10:9] = op.
    - For op 11:
      - tuser[8:0] = latched rf_addr.
      - tuser[11+k] = 1 only, where k = (dpe_start + counter) mod DPES.
      - Wrap goes from DPE 63 to DPE 0.
    - For op 10 and op 01:
      - tuser[8:0] = 0 and tuser[74:11] = 0.
      - Remaining is forced to 1 (single beat).
    - Increment the counter. When the last beat loads, return to IDLE.
- Latency:
  - A command is accepted at edge N.
  - The first data word can be consumed at edge N+1, and appears on tvalid after edge N+1.
- Data arriving in IDLE or INST is not consumed (data_ready = 0).
- No two commands overlap. A new command is only accepted in IDLE.

Test Plan:
- Reset then idle:
  - rst low for 2 cycles, then high.
  - Required: tvalid = 0, cmd_ready = 1 after the first edge, busy = 0.
- Weight burst with wrap:
  - cmd op = 11, rf_addr = 1, dpe_start = 62, len = 4. Data words W0..W3 supplied, tready = 1.
  - Required: 4 consecutive beats with tuser[8:0] = 1 and tuser[10:9] = 11.
  - One-hot select bits in order: 73, 74, 11, 12.
  - tlast = 1 on each beat; tdata = W0..W3.
- Full burst:
  - len = 0, dpe_start = 0.
  - Required: 64 beats walking tuser bits 11..74; busy drops after the last handshake.
- Vectors:
  - op 10 with data = 0x01 repeated, then op 01 with data = 0x02 repeated.
  - Required: tuser = 0x400...|[10:9] = 10 for the first beat and [10:9] = 01 for the second, select field 0, tdata unchanged.
- Instruction:
  - op 00 with cmd_inst = 0x8000200E (ACM_EN = 1, RLS = 1, LST = 1, RF_ADDR = 1, RLS_OP = 1), with data_valid held high.
  - Required: one beat with tdata[31:0] = 0x8000200E, upper bits 0, tuser = 0, data_ready stays 0.
- Backpressure and reset abort:
  - Weight burst of 3 with tready toggled 1,0,0,1,…
  - Required: no beat lost or duplicated, outputs stable while stalled.
  - Asserting rst during beat 2 clears tvalid immediately, and the next command starts clean.
